alu_bist: RTL
=============

ALU_BIST -- requirements
Module: alu_bist

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, meaning clock cycles a vector is held before the ALU output is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  run request; sampled each cycle; acted on only in IDLE or DONE.
REQ-005 alu_a  output  3  operand a driven to the ALU under test.
REQ-006 alu_b  output  3  operand b driven to the ALU under test.
REQ-007 alu_op  output  2  opcode driven to the ALU under test (00 ADD, 01 SUB, 10 AND, 11 OR).
REQ-008 alu_y  input  3  combinational result returned by the ALU under test.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  high after a completed sweep, until next accepted start or reset.
REQ-011 pass  output  1  high when done is high and err_count is zero.
REQ-012 err_count  output  9  number of mismatching vectors in the current or last sweep.
REQ-013 fail_vec  output  8  {op,a,b} of the first mismatching vector; 0 if none.
REQ-014 fail_y  output  3  alu_y observed at the first mismatch; 0 if none.

Function
REQ-015 Block SHALL sweep all 256 vectors, index idx[7:0] = {op[1:0], a[2:0], b[2:0]}, in ascending order 0..255.
REQ-016 alu_op, alu_a, alu_b SHALL be driven directly from registered idx fields; 0 in IDLE, last vector (8'hFF fields) held in DONE.
REQ-017 Expected result SHALL be: ADD (a+b) mod 8; SUB (a-b) mod 8, two's-complement wrap; AND a&b; OR a|b; all 3 bits wide.
REQ-018 FSM states SHALL be IDLE, SETTLE, CHECK, DONE.
REQ-019 IDLE/DONE with start=1: idx<=0, err_count<=0, fail_vec<=0, fail_y<=0, settle counter<=SETTLE_CYCLES, go to SETTLE.
REQ-020 SETTLE: decrement settle counter each cycle; on the cycle the counter equals 1 go to CHECK.
REQ-021 CHECK (exactly one cycle): compare alu_y with expected; on mismatch increment err_count and, if err_count was 0, capture fail_vec<=idx and fail_y<=alu_y.
REQ-022 CHECK with idx==255: go to DONE; otherwise idx<=idx+1, reload settle counter, go to SETTLE.
REQ-023 Each vector SHALL occupy SETTLE_CYCLES+1 cycles; a sweep occupies 256*(SETTLE_CYCLES+1) cycles from the start-accepting edge to the edge entering DONE.
REQ-024 busy SHALL be high exactly in SETTLE and CHECK; done exactly in DONE; busy and done never both high.
REQ-025 start while busy SHALL be ignored with no effect on idx, counters or state.
REQ-026 err_count SHALL not wrap; its maximum reachable value 256 fits in 9 bits.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, idx 0, settle counter 0, err_count 0, fail_vec 0, fail_y 0, busy 0, done 0, pass 0, alu_a/alu_b/alu_op 0, including mid-sweep.
REQ-028 After rst_n deasserts, the block SHALL remain in IDLE until start is sampled high.

Structure
REQ-029 Shared package alu_pkg SHALL hold the data width constant (3), opcode constants OP_ADD/OP_SUB/OP_AND/OP_OR, and the FSM state type.
REQ-030 Expected-result computation SHALL be a combinational sub-module alu_ref_model (inputs a, b, op; output y_exp); FSM, counters and capture registers stay in alu_bist.

Verification
REQ-031 Correct ALU attached, SETTLE_CYCLES=1, pulse start -> done and pass high after 512 cycles, err_count 0, fail_vec 0.
REQ-032 alu_y bit0 forced 0 -> done after 512 cycles, pass 0, err_count 128, fail_vec 8'h01, fail_y 3'b000.
REQ-033 ALU SUB replaced by b-a -> first failure fail_vec 8'h41 (op 01, a 0, b 1), fail_y 3'b001, pass 0.
REQ-034 SETTLE_CYCLES=3 with correct ALU -> done after 1024 cycles; alu_a/alu_b/alu_op stable for 4 cycles per vector.
REQ-035 start pulsed again at cycle 100 of a sweep -> ignored, done still at cycle 512; rst_n low at cycle 200 -> all outputs 0, IDLE, no done.
REQ-036 start in DONE -> err_count, fail_vec, fail_y cleared, busy high next cycle, full new sweep runs.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared constants and FSM state type for the ALU self-test block
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Operand / result width of the ALU under test
  localparam int DATA_W = 3;

  // Opcodes driven on alu_op
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // Sweep controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_ref_model.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ref_model
//  Purpose  : Golden combinational ALU used to predict the expected result
//  Revision : 1.0 - initial release
// ============================================================================
module alu_ref_model
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] y_exp
);

  // Arithmetic results truncate to DATA_W bits, giving mod-8 wrap
  always_comb begin
    y_exp = '0;
    case (op)
      OP_ADD:  y_exp = a + b;
      OP_SUB:  y_exp = a - b;
      OP_AND:  y_exp = a & b;
      OP_OR:   y_exp = a | b;
      default: y_exp = '0;
    endcase
  end

endmodule : alu_ref_model
`default_nettype wire

// File: rtl/alu_bist.sv
`default_nettype none
// ============================================================================
//  Module   : alu_bist
//  Purpose  : Exhaustive built-in self test for a 3-bit, 4-op ALU. Sweeps all
//             256 {op,a,b} vectors, counts mismatches and captures the first.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_bist
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] alu_y,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [8:0]        err_count,
  output logic [7:0]        fail_vec,
  output logic [DATA_W-1:0] fail_y
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_t            state_q, state_d;
  logic [7:0]        idx_q, idx_d;
  logic [3:0]        settle_q, settle_d;
  logic [8:0]        err_q, err_d;
  logic [7:0]        fail_vec_q, fail_vec_d;
  logic [DATA_W-1:0] fail_y_q, fail_y_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [DATA_W-1:0] y_exp;

  // Golden result for the vector currently applied to the ALU
  alu_ref_model u_ref (
    .a     (idx_q[5:3]),
    .b     (idx_q[2:0]),
    .op    (idx_q[7:6]),
    .y_exp (y_exp)
  );

  // Next-state logic: sweep sequencing, mismatch counting, first-fail capture
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    settle_d   = settle_q;
    err_d      = err_q;
    fail_vec_d = fail_vec_q;
    fail_y_d   = fail_y_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          idx_d      = 8'd0;
          err_d      = 9'd0;
          fail_vec_d = 8'd0;
          fail_y_d   = '0;
          settle_d   = SETTLE_INIT;
          state_d    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        settle_d = settle_q - 4'd1;
        if (settle_q == 4'd1) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (alu_y != y_exp) begin
          // Saturate rather than wrap; 256 is the real ceiling anyway
          if (err_q != 9'h1FF) err_d = err_q + 9'd1;
          if (err_q == 9'd0) begin
            fail_vec_d = idx_q;
            fail_y_d   = alu_y;
          end
        end
        if (idx_q == 8'hFF) begin
          state_d = ST_DONE;
        end else begin
          idx_d    = idx_q + 8'd1;
          settle_d = SETTLE_INIT;
          state_d  = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Status outputs are registered copies of what the next state implies
    busy_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_d == 9'd0);
  end

  // State and output registers, cleared asynchronously by rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= 8'd0;
      settle_q   <= 4'd0;
      err_q      <= 9'd0;
      fail_vec_q <= 8'd0;
      fail_y_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      settle_q   <= settle_d;
      err_q      <= err_d;
      fail_vec_q <= fail_vec_d;
      fail_y_q   <= fail_y_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign alu_op    = idx_q[7:6];
  assign alu_a     = idx_q[5:3];
  assign alu_b     = idx_q[2:0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_vec_q;
  assign fail_y    = fail_y_q;

endmodule : alu_bist
`default_nettype wire
